// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Constants shared by mem_access_unit and memory_ram: the default address and
// data widths of the 512-word RAM, the width and ceiling of the access wait
// counter, and the access-controller state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package mem_pkg;

   localparam int unsigned MEM_ADDR_W = 9;
   localparam int unsigned MEM_DATA_W = 32;

   // The wait counter is 4 bits wide, so at most 15 extra strobe cycles.
   localparam int unsigned WAIT_W   = 4;
   localparam int unsigned WAIT_MAX = 15;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACCESS  = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } mau_state_e;

   // Counter load value for a given number of extra wait cycles. Values
   // beyond the counter range saturate instead of wrapping to a short access.
   function automatic logic [WAIT_W-1:0] wait_load(input int unsigned cycles);
      if (cycles > WAIT_MAX) begin
         return WAIT_W'(WAIT_MAX);
      end else begin
         return WAIT_W'(cycles);
      end
   endfunction

endpackage : mem_pkg

// File: rtl/memory_ram.sv
// -----------------------------------------------------------------------------
// memory_ram
// Synchronous single-port RAM (2**ADDR_W words of DATA_W bits).
// Ports:
//   clk          in   clock, rising edge
//   read         in   read strobe; data_output updates at the same edge
//   write        in   write strobe; word at address_in takes data_input
//   address_in   in   word address
//   data_input   in   write data
//   data_output  out  registered read data; holds between reads
// -----------------------------------------------------------------------------
module memory_ram
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_W = MEM_ADDR_W,
   parameter int unsigned DATA_W = MEM_DATA_W
) (
   input  logic              clk,
   input  logic              read,
   input  logic              write,
   input  logic [ADDR_W-1:0] address_in,
   input  logic [DATA_W-1:0] data_input,
   output logic [DATA_W-1:0] data_output
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem_r [0:DEPTH-1];

   // Storage array write port.
   always_ff @(posedge clk) begin
      if (write) begin
         mem_r[address_in] <= data_input;
      end else begin
         mem_r[address_in] <= mem_r[address_in];
      end
   end

   // Registered read port; output holds its last value when not reading.
   always_ff @(posedge clk) begin
      if (read) begin
         data_output <= mem_r[address_in];
      end else begin
         data_output <= data_output;
      end
   end

endmodule : memory_ram

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Single-request memory access controller between the MAR/MDR side of the
// datapath and memory_ram. A request is accepted only in IDLE; its address,
// write data and direction are latched, the matching RAM strobe is held for
// 1+WAIT_CYCLES cycles, read data is captured into rdata one cycle later, and
// completion is flagged by a one-cycle done pulse.
// Ports:
//   clk        in   clock, rising edge
//   clear      in   synchronous active-low reset
//   req        in   request, sampled only in IDLE
//   we         in   1 = write, 0 = read, sampled with req
//   addr       in   request address, sampled with req
//   wdata      in   request write data, sampled with req
//   busy       out  high in every state except IDLE
//   done       out  one-cycle completion pulse
//   rdata      out  last captured read data
//   mem_read   out  RAM read strobe
//   mem_write  out  RAM write strobe
//   mem_addr   out  RAM address
//   mem_wdata  out  RAM write data
//   mem_rdata  in   RAM read data, valid the cycle after a read edge
// -----------------------------------------------------------------------------
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_W      = MEM_ADDR_W,
   parameter int unsigned DATA_W      = MEM_DATA_W,
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic              clk,
   input  logic              clear,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [WAIT_W-1:0] WAIT_LOAD = wait_load(WAIT_CYCLES);

   mau_state_e        state_r;
   mau_state_e        state_s;
   logic [WAIT_W-1:0] count_r;
   logic [WAIT_W-1:0] count_s;
   logic              op_r;       // latched direction: 1 = write
   logic              op_s;
   logic              accept_s;   // request taken at this edge
   logic              capture_s;  // RAM read data captured at this edge

   // Next-state, counter and op-bit decode.
   always_comb begin
      state_s   = state_r;
      count_s   = count_r;
      op_s      = op_r;
      accept_s  = 1'b0;
      capture_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (req) begin
               state_s  = ST_ACCESS;
               count_s  = WAIT_LOAD;
               op_s     = we;
               accept_s = 1'b1;
            end else begin
               state_s  = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            if (count_r == {WAIT_W{1'b0}}) begin
               // Reads need one more cycle for the RAM output register.
               if (op_r) begin
                  state_s = ST_DONE;
               end else begin
                  state_s = ST_CAPTURE;
               end
            end else begin
               state_s = ST_ACCESS;
               count_s = count_r - WAIT_W'(1);
            end
         end
         ST_CAPTURE: begin
            capture_s = 1'b1;
            state_s   = ST_DONE;
         end
         ST_DONE: begin
            // req is deliberately ignored here; it is taken in the next IDLE.
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State, counter and latched-request registers.
   always_ff @(posedge clk) begin
      if (!clear) begin
         state_r   <= ST_IDLE;
         count_r   <= {WAIT_W{1'b0}};
         op_r      <= 1'b0;
         mem_addr  <= {ADDR_W{1'b0}};
         mem_wdata <= {DATA_W{1'b0}};
      end else begin
         state_r <= state_s;
         count_r <= count_s;
         op_r    <= op_s;
         // Address/data hold their last values outside an accepted request.
         if (accept_s) begin
            mem_addr  <= addr;
            mem_wdata <= wdata;
         end else begin
            mem_addr  <= mem_addr;
            mem_wdata <= mem_wdata;
         end
      end
   end

   // Registered status and strobe outputs, decoded from the next state so
   // they line up with the state register and never pass req through
   // combinationally.
   always_ff @(posedge clk) begin
      if (!clear) begin
         busy      <= 1'b0;
         done      <= 1'b0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
      end else begin
         busy      <= (state_s != ST_IDLE);
         done      <= (state_s == ST_DONE);
         mem_write <= (state_s == ST_ACCESS) &&  op_s;
         mem_read  <= (state_s == ST_ACCESS) && !op_s;
      end
   end

   // Read holding register (MDR feed); only a completing read updates it.
   always_ff @(posedge clk) begin
      if (!clear) begin
         rdata <= {DATA_W{1'b0}};
      end else if (capture_s) begin
         rdata <= mem_rdata;
      end else begin
         rdata <= rdata;
      end
   end

endmodule : mem_access_unit

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
// Two controller/RAM pairs: unit 0 with WAIT_CYCLES=0, unit 1 with
// WAIT_CYCLES=2. Each request pushes its expected latency and rdata onto a
// scoreboard queue; the entry is popped and compared when done is observed.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;
   import mem_pkg::*;

   localparam int AW = 9;
   localparam int DW = 32;

   logic          clk;
   logic          clear;
   logic          req       [2];
   logic          we        [2];
   logic [AW-1:0] addr      [2];
   logic [DW-1:0] wdata     [2];
   logic          busy      [2];
   logic          done      [2];
   logic [DW-1:0] rdata     [2];
   logic          mem_read  [2];
   logic          mem_write [2];
   logic [AW-1:0] mem_addr  [2];
   logic [DW-1:0] mem_wdata [2];
   logic [DW-1:0] mem_rdata [2];

   mem_access_unit #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(0)) u_mau0 (
      .clk(clk), .clear(clear), .req(req[0]), .we(we[0]), .addr(addr[0]),
      .wdata(wdata[0]), .busy(busy[0]), .done(done[0]), .rdata(rdata[0]),
      .mem_read(mem_read[0]), .mem_write(mem_write[0]), .mem_addr(mem_addr[0]),
      .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
   );

   memory_ram #(.ADDR_W(AW), .DATA_W(DW)) u_ram0 (
      .clk(clk), .read(mem_read[0]), .write(mem_write[0]),
      .address_in(mem_addr[0]), .data_input(mem_wdata[0]),
      .data_output(mem_rdata[0])
   );

   mem_access_unit #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(2)) u_mau1 (
      .clk(clk), .clear(clear), .req(req[1]), .we(we[1]), .addr(addr[1]),
      .wdata(wdata[1]), .busy(busy[1]), .done(done[1]), .rdata(rdata[1]),
      .mem_read(mem_read[1]), .mem_write(mem_write[1]), .mem_addr(mem_addr[1]),
      .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
   );

   memory_ram #(.ADDR_W(AW), .DATA_W(DW)) u_ram1 (
      .clk(clk), .read(mem_read[1]), .write(mem_write[1]),
      .address_in(mem_addr[1]), .data_input(mem_wdata[1]),
      .data_output(mem_rdata[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      int          unit;
      logic        is_write;
      logic [31:0] exp_rdata;
      int          exp_lat;
   } sb_item_t;

   sb_item_t    sb_q [$];
   logic [31:0] model_mem  [2][512];
   logic [31:0] last_rdata [2];

   task automatic check_val(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Issue one request at the current negedge and follow it to completion.
   // With hold set, req stays high and addr switches to alt_a while busy.
   task automatic run_op(input int u, input logic w, input logic [8:0] a,
                         input logic [31:0] d, input bit hold,
                         input logic [8:0] alt_a);
      int       wc;
      int       n;
      int       done_n;
      int       wr_cnt;
      int       rd_cnt;
      sb_item_t it;
      sb_item_t got;
      wc = (u == 0) ? 0 : 2;
      it.unit     = u;
      it.is_write = w;
      it.exp_lat  = w ? (2 + wc) : (3 + wc);
      if (w) begin
         it.exp_rdata    = last_rdata[u];
         model_mem[u][a] = d;
      end else begin
         it.exp_rdata  = model_mem[u][a];
         last_rdata[u] = model_mem[u][a];
      end
      sb_q.push_back(it);

      req[u] = 1'b1; we[u] = w; addr[u] = a; wdata[u] = d;
      n = 0; done_n = 0; wr_cnt = 0; rd_cnt = 0;
      while (done_n == 0 && n < 20) begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            if (hold) addr[u] = alt_a;
            else      req[u]  = 1'b0;
         end
         check_val($sformatf("u%0d busy", u), 32'(busy[u]), 32'd1);
         check_val($sformatf("u%0d mem_addr", u), 32'(mem_addr[u]), 32'(a));
         if (mem_write[u]) begin
            wr_cnt++;
            check_val($sformatf("u%0d mem_wdata", u), mem_wdata[u], d);
         end
         if (mem_read[u]) rd_cnt++;
         if (done[u]) done_n = n;
      end

      if (sb_q.size() == 0) begin
         check_val("sb_empty", 32'd0, 32'd1);
      end else begin
         got = sb_q.pop_front();
         check_val($sformatf("u%0d latency", u), 32'(done_n), 32'(got.exp_lat));
         check_val($sformatf("u%0d rdata", u), rdata[u], got.exp_rdata);
         check_val($sformatf("u%0d wr_strobes", u), 32'(wr_cnt),
                   got.is_write ? 32'(1 + wc) : 32'd0);
         check_val($sformatf("u%0d rd_strobes", u), 32'(rd_cnt),
                   got.is_write ? 32'd0 : 32'(1 + wc));
      end

      @(negedge clk);
      check_val($sformatf("u%0d done_pulse", u), 32'(done[u]), 32'd0);
      check_val($sformatf("u%0d idle_busy", u), 32'(busy[u]), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int u = 0; u < 2; u++) begin
         req[u] = 1'b0; we[u] = 1'b0; addr[u] = '0; wdata[u] = '0;
         last_rdata[u] = 32'd0;
         for (int k = 0; k < 512; k++) model_mem[u][k] = 32'd0;
      end

      // Reset state
      clear = 1'b0;
      repeat (2) @(negedge clk);
      for (int u = 0; u < 2; u++) begin
         check_val("rst busy", 32'(busy[u]), 32'd0);
         check_val("rst done", 32'(done[u]), 32'd0);
         check_val("rst mem_read", 32'(mem_read[u]), 32'd0);
         check_val("rst mem_write", 32'(mem_write[u]), 32'd0);
         check_val("rst mem_addr", 32'(mem_addr[u]), 32'd0);
         check_val("rst mem_wdata", mem_wdata[u], 32'd0);
         check_val("rst rdata", rdata[u], 32'd0);
      end
      clear = 1'b1;
      @(negedge clk);

      // WAIT_CYCLES=0: write/readback, back-to-back at minimum spacing
      run_op(0, 1'b1, 9'd5, 32'h45, 1'b0, 9'd0);
      run_op(0, 1'b0, 9'd5, 32'h0, 1'b0, 9'd0);
      run_op(0, 1'b1, 9'd7, 32'h77, 1'b0, 9'd0);
      run_op(0, 1'b1, 9'd0, 32'hFFFF_FFFF, 1'b0, 9'd0);
      run_op(0, 1'b0, 9'd0, 32'h0, 1'b0, 9'd0);

      // WAIT_CYCLES=2
      run_op(1, 1'b1, 9'd10, 32'd420, 1'b0, 9'd0);
      run_op(1, 1'b0, 9'd10, 32'h0, 1'b0, 9'd0);
      run_op(1, 1'b1, 9'd511, 32'hDEAD_BEEF, 1'b0, 9'd0);
      run_op(1, 1'b1, 9'd3, 32'h1234_5678, 1'b0, 9'd0);
      run_op(1, 1'b0, 9'd511, 32'h0, 1'b0, 9'd0);

      // Held req with another address during busy; accepted once IDLE
      run_op(0, 1'b0, 9'd5, 32'h0, 1'b1, 9'd7);
      run_op(0, 1'b0, 9'd7, 32'h0, 1'b0, 9'd0);

      // Reset in the middle of a read
      req[0] = 1'b1; we[0] = 1'b0; addr[0] = 9'd5;
      @(negedge clk);
      req[0] = 1'b0;
      check_val("midrst strobe_before", 32'(mem_read[0]), 32'd1);
      clear = 1'b0;
      @(negedge clk);
      clear = 1'b1;
      last_rdata[0] = 32'd0;
      last_rdata[1] = 32'd0;
      check_val("midrst mem_read", 32'(mem_read[0]), 32'd0);
      check_val("midrst busy", 32'(busy[0]), 32'd0);
      check_val("midrst rdata", rdata[0], 32'd0);
      check_val("midrst rdata_u1", rdata[1], 32'd0);
      for (int k = 0; k < 4; k++) begin
         check_val("midrst no_done", 32'(done[0]), 32'd0);
         @(negedge clk);
      end
      run_op(0, 1'b0, 9'd5, 32'h0, 1'b0, 9'd0);

      // req together with clear: reset wins, request dropped
      req[0] = 1'b1; we[0] = 1'b1; addr[0] = 9'd9; wdata[0] = 32'hBAD;
      clear = 1'b0;
      @(negedge clk);
      req[0] = 1'b0;
      clear = 1'b1;
      for (int k = 0; k < 3; k++) begin
         check_val("rstreq mem_write", 32'(mem_write[0]), 32'd0);
         check_val("rstreq mem_read", 32'(mem_read[0]), 32'd0);
         check_val("rstreq busy", 32'(busy[0]), 32'd0);
         check_val("rstreq mem_addr", 32'(mem_addr[0]), 32'd0);
         @(negedge clk);
      end

      check_val("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_mem_access_unit
